// File: rtl/rdyvld_src.sv
// Ready/valid burst source: emits cfg_count words seed, seed+step, ... and
// keeps per-burst transfer and stall statistics.
module rdyvld_src #(
    parameter int width = 32,
    parameter int cntw  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [width-1:0] cfg_seed,
    input  logic [width-1:0] cfg_step,
    input  logic [cntw-1:0]  cfg_count,
    output logic             out1_vld,
    input  logic             out1_rdy,
    output logic [width-1:0] out1_dat,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [cntw-1:0]  sent_cnt,
    output logic [cntw-1:0]  stall_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state, state_nxt;
    logic [width-1:0] step_q, step_nxt, dat_nxt;
    logic [cntw-1:0]  count_q, count_nxt, sent_nxt, stall_nxt;
    logic             done_nxt, aborted_nxt;
    logic             xfer, last;

    assign out1_vld = (state == SEND);
    assign busy     = (state == SEND);
    assign xfer     = out1_vld && out1_rdy;
    assign last     = (sent_cnt + cntw'(1)) == count_q;

    always_comb begin
        state_nxt   = state;
        step_nxt    = step_q;
        count_nxt   = count_q;
        dat_nxt     = out1_dat;
        sent_nxt    = sent_cnt;
        stall_nxt   = stall_cnt;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sent_nxt  = '0;
                    stall_nxt = '0;
                    if (cfg_count != '0) begin
                        state_nxt = SEND;
                        dat_nxt   = cfg_seed;
                        step_nxt  = cfg_step;
                        count_nxt = cfg_count;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            SEND: begin
                if (!out1_rdy && stall_cnt != '1)
                    stall_nxt = stall_cnt + cntw'(1);
                // A transfer of the final word wins over a simultaneous abort.
                if (xfer) begin
                    sent_nxt = sent_cnt + cntw'(1);
                    dat_nxt  = out1_dat + step_q;
                end
                if (xfer && last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (abort) begin
                    state_nxt   = IDLE;
                    done_nxt    = 1'b1;
                    aborted_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step_q    <= '0;
            count_q   <= '0;
            out1_dat  <= '0;
            sent_cnt  <= '0;
            stall_cnt <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_q    <= step_nxt;
            count_q   <= count_nxt;
            out1_dat  <= dat_nxt;
            sent_cnt  <= sent_nxt;
            stall_cnt <= stall_nxt;
            done      <= done_nxt;
            aborted   <= aborted_nxt;
        end
    end

endmodule

// File: tb/tb_rdyvld_src.sv
// Directed bench for rdyvld_src: a 32-bit instance for the main scenarios and
// an 8-bit instance for data wrap-around.
module tb_rdyvld_src;

    logic        clk = 1'b0;
    logic        rst, start, abort, out1_rdy;
    logic [31:0] cfg_seed, cfg_step;
    logic [15:0] cfg_count;
    logic        out1_vld, busy, done, aborted;
    logic [31:0] out1_dat;
    logic [15:0] sent_cnt, stall_cnt;

    logic        start8, abort8, rdy8;
    logic [7:0]  seed8, step8;
    logic [15:0] count8;
    logic        vld8, busy8, done8, aborted8;
    logic [7:0]  dat8;
    logic [15:0] sent8, stall8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rdyvld_src #(.width(32), .cntw(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_seed(cfg_seed), .cfg_step(cfg_step), .cfg_count(cfg_count),
        .out1_vld(out1_vld), .out1_rdy(out1_rdy), .out1_dat(out1_dat),
        .busy(busy), .done(done), .aborted(aborted),
        .sent_cnt(sent_cnt), .stall_cnt(stall_cnt)
    );

    rdyvld_src #(.width(8), .cntw(16)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8),
        .cfg_seed(seed8), .cfg_step(step8), .cfg_count(count8),
        .out1_vld(vld8), .out1_rdy(rdy8), .out1_dat(dat8),
        .busy(busy8), .done(done8), .aborted(aborted8),
        .sent_cnt(sent8), .stall_cnt(stall8)
    );

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out1_vld, busy, done, aborted} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {out1_vld, busy, done, aborted});
        end
        checks++;
        if (out1_dat !== 32'd0 || sent_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: got dat=%0h sent=%0d stall=%0d expected 0/0/0", out1_dat, sent_cnt, stall_cnt);
        end
        checks++;
        if ({vld8, busy8, done8, aborted8, dat8} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_8bit: got %h expected 000", {vld8, busy8, done8, aborted8, dat8});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [31:0] exp_dat [4] = '{32'd5, 32'd8, 32'd11, 32'd14};
        @(negedge clk);
        cfg_seed = 32'd5; cfg_step = 32'd3; cfg_count = 16'd4;
        out1_rdy = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out1_vld, busy} !== 2'b11 || out1_dat !== exp_dat[i]) begin
                errors++;
                $display("[TB] FAIL basic_word%0d: got vld/busy=%b dat=%0d expected 11 dat=%0d", i, {out1_vld, busy}, out1_dat, exp_dat[i]);
            end
            @(negedge clk);
        end
        checks++;
        if ({out1_vld, busy, done, aborted} !== 4'b0010 || sent_cnt !== 16'd4 || stall_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL basic_done: got flags=%b sent=%0d stall=%0d expected 0010 4 0", {out1_vld, busy, done, aborted}, sent_cnt, stall_cnt);
        end
        @(negedge clk);
        checks++;
        if ({done, aborted} !== 2'b00 || sent_cnt !== 16'd4) begin
            errors++;
            $display("[TB] FAIL basic_pulse: got done/aborted=%b sent=%0d expected 00 4", {done, aborted}, sent_cnt);
        end
    endtask

    task automatic test_stall;
        logic [31:0] exp_dat [4] = '{32'd5, 32'd8, 32'd11, 32'd14};
        @(negedge clk);
        cfg_seed = 32'd5; cfg_step = 32'd3; cfg_count = 16'd4;
        out1_rdy = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int w = 0; w < 4; w++) begin
            for (int s = 0; s < 4; s++) begin
                checks++;
                if (out1_vld !== 1'b1 || out1_dat !== exp_dat[w]) begin
                    errors++;
                    $display("[TB] FAIL stall_w%0d_c%0d: got vld=%b dat=%0d expected 1 %0d", w, s, out1_vld, out1_dat, exp_dat[w]);
                end
                out1_rdy = (s == 3);
                // A start during SEND must not disturb the running burst.
                start = (w == 1 && s == 0);
                if (start) begin
                    cfg_seed = 32'd100; cfg_count = 16'd1;
                end
                @(negedge clk);
                start = 1'b0;
            end
        end
        out1_rdy = 1'b0;
        checks++;
        if ({out1_vld, done, aborted} !== 3'b010 || sent_cnt !== 16'd4 || stall_cnt !== 16'd12) begin
            errors++;
            $display("[TB] FAIL stall_done: got flags=%b sent=%0d stall=%0d expected 010 4 12", {out1_vld, done, aborted}, sent_cnt, stall_cnt);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || stall_cnt !== 16'd12) begin
            errors++;
            $display("[TB] FAIL stall_hold: got done=%b stall=%0d expected 0 12", done, stall_cnt);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] exp_dat [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        @(negedge clk);
        seed8 = 8'hFE; step8 = 8'h01; count8 = 16'd4; rdy8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (vld8 !== 1'b1 || dat8 !== exp_dat[i]) begin
                errors++;
                $display("[TB] FAIL wrap_word%0d: got vld=%b dat=%h expected 1 %h", i, vld8, dat8, exp_dat[i]);
            end
            @(negedge clk);
        end
        checks++;
        if ({vld8, done8, aborted8} !== 3'b010 || sent8 !== 16'd4) begin
            errors++;
            $display("[TB] FAIL wrap_done: got flags=%b sent=%0d expected 010 4", {vld8, done8, aborted8}, sent8);
        end
    endtask

    task automatic test_zero_count;
        @(negedge clk);
        cfg_count = 16'd0; out1_rdy = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({out1_vld, busy, done, aborted} !== 4'b0010 || sent_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL zero_done: got flags=%b sent=%0d stall=%0d expected 0010 0 0", {out1_vld, busy, done, aborted}, sent_cnt, stall_cnt);
        end
        @(negedge clk);
        checks++;
        if ({out1_vld, busy, done, aborted} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL zero_after: got flags=%b expected 0000", {out1_vld, busy, done, aborted});
        end
    endtask

    task automatic test_abort(input int abort_at, input logic exp_ab);
        @(negedge clk);
        cfg_seed = 32'd5; cfg_step = 32'd3; cfg_count = 16'd10;
        out1_rdy = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < abort_at; i++) begin
            checks++;
            if (out1_vld !== 1'b1 || out1_dat !== 32'(5 + 3 * i)) begin
                errors++;
                $display("[TB] FAIL abort%0d_word%0d: got vld=%b dat=%0d expected 1 %0d", abort_at, i, out1_vld, out1_dat, 5 + 3 * i);
            end
            abort = (i == abort_at - 1);
            @(negedge clk);
        end
        // Holding abort into IDLE must not produce another pulse.
        checks++;
        if ({out1_vld, busy, done, aborted} !== {3'b001, exp_ab} || sent_cnt !== 16'(abort_at)) begin
            errors++;
            $display("[TB] FAIL abort%0d_end: got flags=%b sent=%0d expected %b %0d", abort_at, {out1_vld, busy, done, aborted}, sent_cnt, {3'b001, exp_ab}, abort_at);
        end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({out1_vld, busy, done, aborted} !== 4'b0000 || sent_cnt !== 16'(abort_at)) begin
            errors++;
            $display("[TB] FAIL abort%0d_idle: got flags=%b sent=%0d expected 0000 %0d", abort_at, {out1_vld, busy, done, aborted}, sent_cnt, abort_at);
        end
    endtask

    task automatic test_reset_mid(input logic rdy_val);
        @(negedge clk);
        cfg_seed = 32'd7; cfg_step = 32'd1; cfg_count = 16'd10;
        out1_rdy = rdy_val; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out1_vld !== 1'b1 || sent_cnt !== (rdy_val ? 16'd2 : 16'd0) || stall_cnt !== (rdy_val ? 16'd0 : 16'd2)) begin
            errors++;
            $display("[TB] FAIL midrst%0d_pre: got vld=%b sent=%0d stall=%0d", rdy_val, out1_vld, sent_cnt, stall_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({out1_vld, busy, done, aborted} !== 4'b0000 || out1_dat !== 32'd0 || sent_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midrst%0d_post: got flags=%b dat=%0h sent=%0d stall=%0d expected all 0", rdy_val, {out1_vld, busy, done, aborted}, out1_dat, sent_cnt, stall_cnt);
        end
        @(negedge clk);
        checks++;
        if ({out1_vld, busy, done, aborted} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midrst%0d_nodone: got flags=%b expected 0000", rdy_val, {out1_vld, busy, done, aborted});
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out1_rdy = 1'b0;
        cfg_seed = '0; cfg_step = '0; cfg_count = '0;
        start8 = 1'b0; abort8 = 1'b0; rdy8 = 1'b0;
        seed8 = '0; step8 = '0; count8 = '0;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero_count();
        test_abort(3, 1'b1);
        test_abort(10, 1'b0);
        test_reset_mid(1'b0);
        test_basic();
        test_reset_mid(1'b1);
        test_basic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
